// File: rtl/mole_game_pkg.sv
// Shared types and widths for the whack-a-mole sequencing controller.
// Also holds the visible-window helper used on every new mole.
package mole_game_pkg;

    localparam int unsigned MS_W    = 16;
    localparam int unsigned MS_WX   = MS_W + 1;
    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned LIVES_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_SHOW  = 3'd2,
        ST_GAP   = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Window shrinks by step per level and saturates at the floor; one spare bit avoids wrap.
    function automatic logic [MS_W-1:0] window_ms(
        input logic [LEVEL_W-1:0] lvl,
        input int unsigned        start_ms,
        input int unsigned        min_ms,
        input int unsigned        step_ms
    );
        logic [MS_WX-1:0] red_s;
        red_s = MS_WX'(lvl) * MS_WX'(step_ms);
        if ((red_s + MS_WX'(min_ms)) >= MS_WX'(start_ms)) begin
            window_ms = MS_W'(min_ms);
        end else begin
            window_ms = MS_W'(MS_WX'(start_ms) - red_s);
        end
    endfunction

endpackage

// File: rtl/ms_downcounter.sv
// Loadable millisecond down-counter; done flags the tick on which the count runs out.
module ms_downcounter
    import mole_game_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [MS_W-1:0] load_val,
    input  logic            tick,
    input  logic            en,
    output logic            done
);

    logic [MS_W-1:0] r_count;

    // Load has priority over a coincident tick so a fresh window starts whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {MS_W{1'b0}};
        end else if (load) begin
            r_count <= load_val;
        end else if (en && tick && (r_count != {MS_W{1'b0}})) begin
            r_count <= r_count - MS_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign done = en & tick & (r_count <= MS_W'(1));

endmodule

// File: rtl/mole_game_controller.sv
// Whack-a-mole sequencer: picks and times moles, tracks lives and level.
// Optional macro PAUSE_EN adds a level-sensitive pause input.
module mole_game_controller
    import mole_game_pkg::*;
#(
    parameter int unsigned N_MOLES        = 10,
    parameter int unsigned START_MS       = 1000,
    parameter int unsigned MIN_MS         = 250,
    parameter int unsigned STEP_MS        = 100,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned GAP_MS         = 200,
    parameter int unsigned READY_MS       = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef PAUSE_EN
    input  logic               pause,
`endif
    input  logic               ms_tick,
    input  logic               start,
    input  logic [4:0]         rng_idx,
    input  logic               hit_pulse,
    input  logic               miss_pulse,
    output logic [N_MOLES-1:0] active_onehot,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives_left,
    output logic               running,
    output logic               game_over,
    output logic               timeout_pulse
);

    state_e             r_state, w_state_nxt;
    logic [N_MOLES-1:0] r_onehot, w_onehot_nxt;
    logic [LEVEL_W-1:0] r_level, w_level_nxt;
    logic [LIVES_W-1:0] r_lives, w_lives_nxt;
    logic [7:0]         r_hits, w_hits_nxt;
    logic [4:0]         r_prev_idx, w_prev_nxt;
    logic               r_timeout, w_timeout_nxt, r_running, r_game_over;
    logic [4:0]         w_raw_idx, w_inc_idx, w_new_idx;
    logic               w_load, w_done, w_in_play, w_paused, w_hit, w_miss;
    logic [MS_W-1:0]    w_load_val;

    assign w_raw_idx = 5'(rng_idx % 5'(N_MOLES));
    assign w_inc_idx = (w_raw_idx == 5'(N_MOLES - 1)) ? 5'd0 : (w_raw_idx + 5'd1);
    assign w_new_idx = (w_raw_idx == r_prev_idx) ? w_inc_idx : w_raw_idx;
    assign w_in_play = (r_state == ST_READY) || (r_state == ST_SHOW) || (r_state == ST_GAP);
`ifdef PAUSE_EN
    assign w_paused  = pause & w_in_play;
`else
    assign w_paused  = 1'b0;
`endif
    assign w_hit     = hit_pulse & ~w_paused;
    assign w_miss    = miss_pulse & ~w_paused;

    ms_downcounter u_ms_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (ms_tick),
        .en       (w_in_play & ~w_paused),
        .done     (w_done)
    );

    // Next-state logic; in SHOW a hit outranks a miss, which outranks window expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_onehot_nxt  = r_onehot;
        w_level_nxt   = r_level;
        w_lives_nxt   = r_lives;
        w_hits_nxt    = r_hits;
        w_prev_nxt    = r_prev_idx;
        w_timeout_nxt = 1'b0;
        w_load        = 1'b0;
        w_load_val    = {MS_W{1'b0}};
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    w_state_nxt  = ST_READY;
                    w_onehot_nxt = {N_MOLES{1'b0}};
                    w_level_nxt  = {LEVEL_W{1'b0}};
                    w_lives_nxt  = LIVES_W'(LIVES);
                    w_hits_nxt   = 8'd0;
                    w_load       = 1'b1;
                    w_load_val   = MS_W'(READY_MS);
                end else begin
                    w_state_nxt  = r_state;
                end
            end
            ST_READY, ST_GAP: begin
                if (w_done) begin
                    w_state_nxt  = ST_SHOW;
                    w_onehot_nxt = {{(N_MOLES-1){1'b0}}, 1'b1} << w_new_idx;
                    w_prev_nxt   = w_new_idx;
                    w_load       = 1'b1;
                    w_load_val   = window_ms(r_level, START_MS, MIN_MS, STEP_MS);
                end else begin
                    w_state_nxt  = r_state;
                end
            end
            ST_SHOW: begin
                if (w_hit) begin
                    w_state_nxt  = ST_GAP;
                    w_onehot_nxt = {N_MOLES{1'b0}};
                    w_load       = 1'b1;
                    w_load_val   = MS_W'(GAP_MS);
                    if (r_hits >= 8'(HITS_PER_LEVEL - 1)) begin
                        w_hits_nxt  = 8'd0;
                        w_level_nxt = (r_level == {LEVEL_W{1'b1}}) ? r_level : (r_level + LEVEL_W'(1));
                    end else begin
                        w_hits_nxt  = r_hits + 8'd1;
                    end
                end else if (w_miss || w_done) begin
                    w_timeout_nxt = ~w_miss;
                    w_lives_nxt   = (r_lives == {LIVES_W{1'b0}}) ? r_lives : (r_lives - LIVES_W'(1));
                    if (r_lives <= LIVES_W'(1)) begin
                        w_state_nxt  = ST_OVER;
                        w_onehot_nxt = {N_MOLES{1'b0}};
                    end else if (w_miss) begin
                        w_state_nxt  = ST_SHOW;
                    end else begin
                        w_state_nxt  = ST_GAP;
                        w_onehot_nxt = {N_MOLES{1'b0}};
                        w_load       = 1'b1;
                        w_load_val   = MS_W'(GAP_MS);
                    end
                end else begin
                    w_state_nxt  = ST_SHOW;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_onehot_nxt = {N_MOLES{1'b0}};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_onehot    <= {N_MOLES{1'b0}};
            r_level     <= {LEVEL_W{1'b0}};
            r_lives     <= LIVES_W'(LIVES);
            r_hits      <= 8'd0;
            r_prev_idx  <= 5'd0;
            r_timeout   <= 1'b0;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_onehot    <= w_onehot_nxt;
            r_level     <= w_level_nxt;
            r_lives     <= w_lives_nxt;
            r_hits      <= w_hits_nxt;
            r_prev_idx  <= w_prev_nxt;
            r_timeout   <= w_timeout_nxt;
            r_running   <= (w_state_nxt == ST_READY) || (w_state_nxt == ST_SHOW) || (w_state_nxt == ST_GAP);
            r_game_over <= (w_state_nxt == ST_OVER);
        end
    end

    assign active_onehot = r_onehot;
    assign level         = r_level;
    assign lives_left    = r_lives;
    assign running       = r_running;
    assign game_over     = r_game_over;
    assign timeout_pulse = r_timeout;

endmodule

// File: doc/mole_game_controller.md
Name: mole_game_controller

Overview:
- Sequencing FSM for the whack-a-mole game; sits between the RNG, the 1 ms tick timer and the mole detector.
- Decides which LED (mole) is lit and for how long, and consumes hit_pulse and miss_pulse from the detector.
- Tracks lives and difficulty level, and raises game over.
- Its active_onehot output drives LEDR and the detector's active_onehot input, replacing the free-running LED toggler.

Parameters:
- N_MOLES, 10, number of LEDs/buttons.
- START_MS, 1000, mole visible window at level 0, in ms.
- MIN_MS, 250, floor of the visible window.
- STEP_MS, 100, window reduction per level.
- HITS_PER_LEVEL, 5, consecutive-or-not hits needed to advance one level.
- LIVES, 3, lives at game start.
- GAP_MS, 200, all-dark gap between moles.
- READY_MS, 2000, countdown after start before the first mole.

Ports:
- clk, in, 1, system clock (50 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- ms_tick, in, 1, single-cycle pulse every 1 ms.
- start, in, 1, single-cycle start request (debounced KEY edge).
- rng_idx, in, 5, free-running random value.
- hit_pulse, in, 1, correct button pressed while armed.
- miss_pulse, in, 1, wrong button pressed.
- active_onehot, out, N_MOLES, currently lit mole; all-zero when none.
- level, out, 4, current difficulty level.
- lives_left, out, 2, remaining lives.
- running, out, 1, high in READY/SHOW/GAP.
- game_over, out, 1, high in OVER.
- timeout_pulse, out, 1, one-cycle pulse when a mole expires unhit.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, active_onehot=0, level=0, lives_left=LIVES.
  - running=0, game_over=0, timeout_pulse=0.
  - Internal counters=0, prev_idx=0.
- States: IDLE, READY, SHOW, GAP, OVER. All transitions take effect on the clock edge following the cause.
- IDLE:
  - Outputs dark.
  - start -> READY: load ms counter with READY_MS, level=0, lives_left=LIVES, hit count=0.
- READY:
  - Counter decrements only on ms_tick.
  - On the tick where the count reaches 0 -> SHOW.
- SHOW entry:
  - idx = rng_idx mod N_MOLES, registered.
  - If idx==prev_idx, use (idx+1) mod N_MOLES instead.
  - active_onehot = 1<<idx, prev_idx = idx.
  - Counter loaded with window = max(MIN_MS, START_MS - level*STEP_MS). Compute in 16 bits, saturating at MIN_MS with no underflow.
- SHOW exits:
  - hit_pulse -> GAP. Increment hit count. When hit count reaches HITS_PER_LEVEL, clear it and increment level (saturating at 15).
  - miss_pulse -> decrement lives. If lives becomes 0 -> OVER; otherwise stay in SHOW with the mole still lit and the window not restarted.
  - Window expires (count 0 on ms_tick) -> timeout_pulse=1 for one cycle, decrement lives. Go to OVER if lives becomes 0, else GAP.
- Simultaneous events in SHOW, same cycle:
  - hit_pulse wins over expiry: counts as a hit, no life lost.
  - hit_pulse and miss_pulse together: hit counts, miss is ignored.
  - hit_pulse, miss_pulse and expiry all together: hit only.
- GAP:
  - active_onehot=0, counter=GAP_MS.
  - Counter reaches 0 -> SHOW (new mole).
  - hit_pulse and miss_pulse are ignored.
- OVER:
  - active_onehot=0, game_over=1, level and lives held for display.
  - start -> READY (new game).
- start is ignored outside IDLE and OVER.
- lives_left never underflows below 0.
- rst_n assertion in any state returns immediately to the reset values, including mid-SHOW.

Optional Feature:
- Macro PAUSE_EN.
- Defined: adds input port pause (1 bit, level).
  - While pause=1 in READY, SHOW or GAP, ms_tick is ignored, hit_pulse and miss_pulse are ignored, and active_onehot keeps its value.
  - running stays 1.
  - Release resumes with the remaining count intact.
- Undefined: no pause port; behaviour as above.

Decomposition:
- Package mole_game_pkg holds:
  - state enum (IDLE, READY, SHOW, GAP, OVER);
  - MS_W=16 counter width;
  - LEVEL_W=4 and LIVES_W=2 width constants.
- Sub-module ms_downcounter:
  - Loadable 16-bit down-counter decremented on ms_tick.
  - Ports: clk, rst_n, load, load_val, tick, en, done pulse.
  - Instantiated once; the FSM reloads it per state.

Test Plan:
- Reset then start, with ms_tick forced every 10 cycles -> running=1. After 2000 ticks a single active_onehot bit is set; idx equals rng_idx mod 10.
- No hits -> after 1000 ticks timeout_pulse and lives_left 3->2, then 200 dark ticks, then a new mole at an index different from the previous one. After the third timeout, game_over=1 and active_onehot=0.
- hit_pulse 50 ticks into each mole, 5 times -> level=1; next window 900 ticks. After 40 hits, level saturates at the 250 ms floor (level>=8 gives a 250-tick window).
- hit_pulse, miss_pulse and window expiry on the same cycle -> treated as a hit, lives unchanged, no timeout_pulse.
- Assert rst_n=0 mid-SHOW (lives=1, level=2) -> next sample shows IDLE values: active_onehot=0, lives_left=3, level=0. start in OVER restarts at READY with lives=3.
- PAUSE_EN: pause high for 500 ticks at 300 ticks into a mole -> the mole remains lit and expires 700 ticks after release.
